// File: rtl/jh_fifo_pkg.sv
// Shared types for the interleaved two-bank FIFO controller.
// Holds the output-buffer depth, the bank selector and the read tag.
package jh_fifo_pkg;

    localparam int OBUF_DEPTH = 4;
    localparam int OBUF_CW    = $clog2(OBUF_DEPTH) + 1;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_sel_t;

    typedef struct packed {
        logic      valid;
        bank_sel_t bank;
    } rd_tag_t;

endpackage

// File: rtl/jh_interleaved_fifo_ctrl_if.sv
// Push/pop handshake bundle of the interleaved FIFO.
// The slave side is the FIFO; the master side is its user.
interface jh_interleaved_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [CW-1:0]         count;

    modport master (
        output wr_valid,
        output wr_data,
        output rd_ready,
        input  wr_ready,
        input  rd_valid,
        input  rd_data,
        input  count
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  rd_ready,
        output wr_ready,
        output rd_valid,
        output rd_data,
        output count
    );

endinterface

// File: rtl/jh_fifo_obuf.sv
// Small register FIFO holding prefetched words ahead of the pop port.
// First-word-fall-through: the head is always visible on pop_data_o.
module jh_fifo_obuf
    import jh_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_ready_i,
    output logic                  pop_valid_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic [OBUF_CW-1:0]    count_o
);

    localparam int PW = $clog2(OBUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [OBUF_CW-1:0]    cnt_q, cnt_d;
    logic                  full;
    logic                  pop;
    logic                  push_ok;

    assign full        = (cnt_q == OBUF_CW'(OBUF_DEPTH));
    assign pop_valid_o = (cnt_q != '0);
    assign pop         = pop_valid_o & pop_ready_i;
    assign push_ok     = push_i & (~full | pop);
    assign pop_data_o  = mem_q[head_q];
    assign count_o     = cnt_q;

    always_comb begin
        head_d = head_q + PW'(pop);
        tail_d = tail_q + PW'(push_ok);
        cnt_d  = cnt_q + OBUF_CW'(push_ok) - OBUF_CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (push_ok) begin
                mem_q[tail_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/jh_interleaved_fifo_ctrl.sv
// FIFO control over two single-port RAM banks holding even/odd entries.
// Reads are prefetched into a small output buffer so push and pop overlap.
module jh_interleaved_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    jh_interleaved_fifo_ctrl_if.slave fifo,
    output logic [$clog2(DEPTH)-2:0]  bank0_addr,
    output logic [$clog2(DEPTH)-2:0]  bank1_addr,
    output logic [DATA_WIDTH-1:0]     bank0_din,
    output logic [DATA_WIDTH-1:0]     bank1_din,
    output logic                      bank0_wr_en,
    output logic                      bank1_wr_en,
    input  logic [DATA_WIDTH-1:0]     bank0_dout,
    input  logic [DATA_WIDTH-1:0]     bank1_dout
);
    import jh_fifo_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    rd_tag_t               tag_q, tag_d;
    logic [OBUF_CW-1:0]    ob_count;
    logic                  ob_valid;
    logic [DATA_WIDTH-1:0] ob_data;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  room;
    logic                  conflict;
    bank_sel_t             wr_bank;
    bank_sel_t             rd_bank;

    assign wr_bank = bank_sel_t'(wr_ptr_q[0]);
    assign rd_bank = bank_sel_t'(rd_ptr_q[0]);

    assign fifo.wr_ready = rst_n & (count_q < CW'(DEPTH));
    assign fifo.rd_valid = ob_valid;
    assign fifo.rd_data  = ob_data;
    assign fifo.count    = count_q;

    assign push = fifo.wr_valid & fifo.wr_ready;
    assign pop  = ob_valid & fifo.rd_ready;

    // A write owns its bank for the cycle; a clashing read waits one cycle.
    assign conflict = push & (wr_bank == rd_bank);
    assign room     = (ob_count + OBUF_CW'(tag_q.valid)) < OBUF_CW'(OBUF_DEPTH);
    assign issue    = rst_n & (wr_ptr_q != rd_ptr_q) & ~conflict & room;

    assign cap_data = (tag_q.bank == BANK1) ? bank1_dout : bank0_dout;

    always_comb begin
        bank0_wr_en = 1'b0;
        bank0_addr  = '0;
        bank0_din   = '0;
        bank1_wr_en = 1'b0;
        bank1_addr  = '0;
        bank1_din   = '0;
        if (issue) begin
            if (rd_bank == BANK0) begin
                bank0_addr = rd_ptr_q[PW-1:1];
            end else begin
                bank1_addr = rd_ptr_q[PW-1:1];
            end
        end
        if (push) begin
            if (wr_bank == BANK0) begin
                bank0_wr_en = 1'b1;
                bank0_addr  = wr_ptr_q[PW-1:1];
                bank0_din   = fifo.wr_data;
            end else begin
                bank1_wr_en = 1'b1;
                bank1_addr  = wr_ptr_q[PW-1:1];
                bank1_din   = fifo.wr_data;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(issue);
        count_d    = count_q + CW'(push) - CW'(pop);
        tag_d      = '0;
        tag_d.valid = issue;
        tag_d.bank  = rd_bank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tag_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tag_q    <= tag_d;
        end
    end

    // Bank dout is registered, so the tagged read lands one cycle after issue.
    jh_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (tag_q.valid),
        .push_data_i (cap_data),
        .pop_ready_i (fifo.rd_ready),
        .pop_valid_o (ob_valid),
        .pop_data_o  (ob_data),
        .count_o     (ob_count)
    );

endmodule

// File: tb/tb_jh_interleaved_fifo_ctrl.sv
// Bench for the interleaved FIFO: bank RAM models, queue-based reference
// model compared every cycle, and a few hand-computed expectations.
module tb_jh_interleaved_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH) - 1;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] b0_addr, b1_addr;
    logic [DW-1:0] b0_din, b1_din;
    logic          b0_we, b1_we;
    logic [DW-1:0] b0_dout, b1_dout;

    jh_interleaved_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    jh_interleaved_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo        (bus),
        .bank0_addr  (b0_addr),
        .bank1_addr  (b1_addr),
        .bank0_din   (b0_din),
        .bank1_din   (b1_din),
        .bank0_wr_en (b0_we),
        .bank1_wr_en (b1_we),
        .bank0_dout  (b0_dout),
        .bank1_dout  (b1_dout)
    );

    // single-port banks with registered read
    logic [DW-1:0] mem0 [DEPTH/2];
    logic [DW-1:0] mem1 [DEPTH/2];

    always @(posedge clk) begin
        if (b0_we) mem0[b0_addr] <= b0_din;
        else       b0_dout <= mem0[b0_addr];
        if (b1_we) mem1[b1_addr] <= b1_din;
        else       b1_dout <= mem1[b1_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // reference model: entries in RAM, reads in flight, output buffer
    logic [DW-1:0] pend_q[$];
    logic [DW-1:0] infl_q[$];
    logic [DW-1:0] ob_q[$];
    int cnt, wr_idx, rd_idx, stalls;

    logic          s_wr_ready, s_rd_valid, s_b0_we, s_b1_we;
    logic [DW-1:0] s_rd_data;
    logic [AW-1:0] s_b0_addr;
    logic [DW-1:0] s_b0_din;
    int            s_count;
    bit            s_stall;
    int            we0_pulses;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        pend_q.delete();
        infl_q.delete();
        ob_q.delete();
        cnt    = 0;
        wr_idx = 0;
        rd_idx = 0;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
        chk({tag, "_count"},    32'(bus.count), 0);
        chk({tag, "_b0_we"},    32'(b0_we), 0);
        chk({tag, "_b1_we"},    32'(b1_we), 0);
        chk({tag, "_b0_addr"},  32'(b0_addr), 0);
        chk({tag, "_b1_addr"},  32'(b1_addr), 0);
    endtask

    task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rr);
        bit push, pop, issue, room, conflict;
        int pb, rb;
        int e_we0, e_we1, e_a0, e_a1, e_d0, e_d1;
        @(negedge clk);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        #1;
        s_wr_ready = bus.wr_ready;
        s_rd_valid = bus.rd_valid;
        s_rd_data  = bus.rd_data;
        s_count    = int'(bus.count);
        s_b0_we    = b0_we;
        s_b1_we    = b1_we;
        s_b0_addr  = b0_addr;
        s_b0_din   = b0_din;
        s_stall    = 1'b0;
        we0_pulses += int'(b0_we);
        if (!rst_n) begin
            chk_idle_reset("rst");
            model_clear();
        end else begin
            push     = wv && (cnt < DEPTH);
            pop      = rr && (ob_q.size() > 0);
            pb       = wr_idx % 2;
            rb       = rd_idx % 2;
            room     = (ob_q.size() + infl_q.size()) < 4;
            conflict = push && (pb == rb);
            issue    = (pend_q.size() > 0) && !conflict && room;
            if ((pend_q.size() > 0) && room && conflict) begin
                stalls++;
                s_stall = 1'b1;
            end
            e_we0 = 0; e_we1 = 0; e_a0 = 0; e_a1 = 0; e_d0 = 0; e_d1 = 0;
            if (issue) begin
                if (rb == 0) e_a0 = rd_idx / 2;
                else         e_a1 = rd_idx / 2;
            end
            if (push) begin
                if (pb == 0) begin
                    e_we0 = 1; e_a0 = wr_idx / 2; e_d0 = int'(wd);
                end else begin
                    e_we1 = 1; e_a1 = wr_idx / 2; e_d1 = int'(wd);
                end
            end
            chk("wr_ready", 32'(bus.wr_ready), 32'(cnt < DEPTH));
            chk("rd_valid", 32'(bus.rd_valid), 32'(ob_q.size() > 0));
            chk("count", 32'(bus.count), 32'(cnt));
            if (ob_q.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(ob_q[0]));
            chk("b0_we", 32'(b0_we), 32'(e_we0));
            chk("b1_we", 32'(b1_we), 32'(e_we1));
            chk("b0_addr", 32'(b0_addr), 32'(e_a0));
            chk("b1_addr", 32'(b1_addr), 32'(e_a1));
            chk("b0_din", 32'(b0_din), 32'(e_d0));
            chk("b1_din", 32'(b1_din), 32'(e_d1));
            // advance the model across the coming edge
            if (pop) void'(ob_q.pop_front());
            while (infl_q.size() > 0) ob_q.push_back(infl_q.pop_front());
            if (issue) begin
                infl_q.push_back(pend_q.pop_front());
                rd_idx = (rd_idx + 1) % DEPTH;
            end
            if (push) begin
                pend_q.push_back(wd);
                wr_idx = (wr_idx + 1) % DEPTH;
            end
            cnt = cnt + int'(push) - int'(pop);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) cycle(1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (cnt > 0 && n < 600) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(cnt), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bubbles;
        bit started;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        rst_n        = 1'b0;
        stalls       = 0;
        we0_pulses   = 0;
        model_clear();

        // reset state and release
        repeat (2) cycle(1'b0, '0, 1'b0);
        chk("reset_wr_ready", 32'(s_wr_ready), 0);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0);
        chk("post_reset_wr_ready", 32'(s_wr_ready), 1);
        chk("post_reset_count", 32'(s_count), 0);

        // single push, three-cycle latency
        we0_pulses = 0;
        cycle(1'b1, 8'hA5, 1'b0);
        chk("t1_b0_we", 32'(s_b0_we), 1);
        chk("t1_b0_addr", 32'(s_b0_addr), 0);
        chk("t1_b0_din", 32'(s_b0_din), 32'h A5);
        cycle(1'b0, '0, 1'b0);
        chk("t1_valid_t1", 32'(s_rd_valid), 0);
        cycle(1'b0, '0, 1'b0);
        chk("t1_valid_t2", 32'(s_rd_valid), 0);
        cycle(1'b0, '0, 1'b0);
        chk("t1_valid_t3", 32'(s_rd_valid), 1);
        chk("t1_data", 32'(s_rd_data), 32'h A5);
        chk("t1_count", 32'(s_count), 1);
        cycle(1'b0, '0, 1'b0);
        chk("t1_b0_pulses", 32'(we0_pulses), 1);

        // fill to capacity, then refuse
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b1, 8'h77, 1'b0);
        chk("full_wr_ready", 32'(s_wr_ready), 0);
        chk("full_count", 32'(s_count), DEPTH);
        chk("full_b0_we", 32'(s_b0_we), 0);
        chk("full_b1_we", 32'(s_b1_we), 0);
        cycle(1'b1, 8'h66, 1'b1);
        chk("full_pop_no_push", 32'(s_b0_we | s_b1_we), 0);
        chk("full_pop_wr_ready", 32'(s_wr_ready), 0);
        drain("full");
        cycle(1'b0, '0, 1'b0);
        chk("empty_count", 32'(s_count), 0);
        chk("empty_rd_valid", 32'(s_rd_valid), 0);

        // bank conflict: write to the bank a prefetch wants
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 8'hC3, 1'b0);
        chk("cf_write_we", 32'(s_b0_we), 1);
        chk("cf_write_addr", 32'(s_b0_addr), 3);
        chk("cf_model_stall", 32'(s_stall), 1);
        cycle(1'b0, '0, 1'b0);
        chk("cf_read_we", 32'(s_b0_we), 0);
        chk("cf_read_addr", 32'(s_b0_addr), 2);
        drain("cf");

        // continuous streaming
        stalls  = 0;
        bubbles = 0;
        started = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 8'($urandom), 1'b1);
            if (started && !s_rd_valid) bubbles++;
            if (s_rd_valid) started = 1'b1;
        end
        chk("cont_bubbles", 32'(bubbles), 0);
        chk("cont_stalls_le1", 32'(stalls <= 1), 1);
        chk("cont_started", 32'(started), 1);

        // random traffic with pointer wrap
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom), 8'($urandom), 1'($urandom));
        end
        drain("rand");

        // reset mid-stream
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        chk("mid_count", 32'(s_count), 37);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle_reset("mid_async");
        model_clear();
        repeat (2) cycle(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        cycle(1'b1, 8'h3C, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b0);
        chk("mid_after_valid", 32'(s_rd_valid), 1);
        chk("mid_after_data", 32'(s_rd_data), 32'h 3C);
        chk("mid_after_count", 32'(s_count), 1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        chk("mid_final_count", 32'(s_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
